smc_access_seq17: RTL and testbench
===================================

Name: smc_access_seq17

Overview:
- Timing sequencer for one static-memory chip select.
- Consumes one access request at a time from the SMC bus-side logic.
- Drives the n_cs/n_oe/n_we strobes through setup, strobe, hold and turnaround phases. Phase lengths come from the 32-bit SMC config word, latched per access.
- Sits between the config register and the external memory pads.

Parameters:
CNT_W, 8, width of phase counter; must be >= 8 (strobe field width)

Ports:
hclk17  input  1  system clock, all logic on rising edge
n_sys_reset17  input  1  synchronous active-low reset
cfg_word17  input  32  SMC config word; [1:0] setup, [3:2] hold, [5:4] turnaround, [15:8] strobe; other bits ignored
req_valid17  input  1  access request pending
req_write17  input  1  1=write, 0=read; qualified by req_valid17
req_ready17  output  1  sequencer can accept a request this cycle
n_cs17  output  1  chip select, active low
n_oe17  output  1  output enable, active low (reads)
n_we17  output  1  write enable, active low (writes)
rd_capture17  output  1  one-cycle pulse: sample read data this cycle
acc_done17  output  1  one-cycle pulse: access phase complete
busy17  output  1  sequencer not in IDLE

Behaviour:
- All outputs registered except req_ready17, which is combinational from state: (state==IDLE).
- Reset values (n_sys_reset17 low at a clock edge): state=IDLE, counter=0, n_cs17=1, n_oe17=1, n_we17=1, rd_capture17=0, acc_done17=0, busy17=0.
- Reset mid-access aborts immediately; strobes are high the cycle after the reset edge, and no done pulse is issued.
- Handshake: accept on req_valid17 && req_ready17 at a rising edge.
  - Latch req_write17 and the setup/hold/turn/strobe fields.
  - cfg_word17 changes after acceptance do not affect the access in flight.
- States:
  - IDLE -> SETUP on accept if setup!=0, else -> STROBE.
  - SETUP: lasts setup cycles (1-3); n_cs17=0, n_oe17=n_we17=1. -> STROBE.
  - STROBE: lasts strobe+1 cycles (1-256); n_cs17=0; n_oe17=0 for reads, n_we17=0 for writes.
    - rd_capture17=1 in the last STROBE cycle of a read.
    - -> HOLD if hold!=0, else -> END.
  - HOLD: lasts hold cycles; n_cs17=0, n_oe17=n_we17=1. -> END.
  - END is not a register state. acc_done17 pulses for the one cycle after the last STROBE/HOLD cycle.
    - In that cycle n_cs17=1.
    - State goes to TURN if turn!=0, else IDLE.
  - TURN: lasts turn cycles; all strobes high, busy17=1. -> IDLE.
- Counter: loaded with (phase length - 1) on phase entry, decrements, phase exits at 0. No wrap is possible: the strobe length of 256 fits CNT_W=8 as load value 255.
- Minimum access (setup=hold=turn=0, strobe=0): strobes low 1 cycle.
- Back-to-back: a request pending during TURN/END is accepted on the first IDLE cycle, so the next access never overlaps TURN.
- busy17=1 in every state except IDLE, including the acc_done17 cycle.

Optional Feature:
SMC_WAIT_EN:
- Defined: adds input n_wait17 (1 bit, active low, externally synchronised).
  - In the last STROBE cycle, n_wait17=0 holds STROBE (counter stays 0, strobes stay asserted).
  - rd_capture17 fires only in the cycle where STROBE actually exits.
  - n_wait17 is ignored in all other states.
- Undefined: port absent; STROBE length fixed by config.

Decomposition:
- Package smc_seq_pkg17: state enum (IDLE, SETUP, STROBE, HOLD, TURN); cfg_word17 field bit-position constants.
- No sub-module. FSM plus counter fits a single module.

Test Plan:
- Read, cfg setup=1 strobe=3 hold=1 turn=0 -> n_cs17 low 6 cycles, n_oe17 low 4 cycles, rd_capture17 in strobe cycle 4, acc_done17 one cycle after hold, req_ready17 back 1 cycle later.
- Write, all fields 0 -> n_we17 low exactly 1 cycle, n_oe17 never low, acc_done17 next cycle, no rd_capture17.
- Back-to-back reads with turn=2, req_valid17 held high -> second n_cs17 falling edge exactly 4 cycles after first access's acc_done17 (END + 2 TURN + IDLE accept).
- Change cfg_word17 strobe from 3 to 10 mid-STROBE -> in-flight strobe stays 4 cycles; next access uses 11.
- n_sys_reset17 low during STROBE of a write -> n_we17/n_cs17 high next cycle, no acc_done17, req_ready17=1 after reset release.
- SMC_WAIT_EN, strobe=1, n_wait17 low 3 cycles from last strobe cycle -> n_oe17 low 5 cycles total, rd_capture17 once, in the cycle n_wait17 returns high.

Source files
------------

// File: rtl/smc_access_seq17_pkg.sv
// Shared types for the SMC access sequencer: FSM states and config word field layout.
package smc_seq_pkg17;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_e;

  localparam int CFG_SETUP_LSB  = 0;
  localparam int CFG_HOLD_LSB   = 2;
  localparam int CFG_TURN_LSB   = 4;
  localparam int CFG_STROBE_LSB = 8;

  typedef struct packed {
    logic [7:0] strobe;
    logic [1:0] turn;
    logic [1:0] hold;
    logic [1:0] setup;
  } cfg_t;

  function automatic cfg_t cfg_unpack(input logic [31:0] w);
    cfg_t c;
    c.setup  = w[CFG_SETUP_LSB  +: 2];
    c.hold   = w[CFG_HOLD_LSB   +: 2];
    c.turn   = w[CFG_TURN_LSB   +: 2];
    c.strobe = w[CFG_STROBE_LSB +: 8];
    return c;
  endfunction

endpackage

// File: rtl/smc_access_seq17_if.sv
// Bus-side request handshake plus memory pad strobes for one chip select.
// SMC_WAIT_EN adds the active-low n_wait17 pad input.
interface smc_access_seq17_if;
  logic [31:0] cfg_word17;
  logic        req_valid17;
  logic        req_write17;
  logic        req_ready17;
  logic        n_cs17;
  logic        n_oe17;
  logic        n_we17;
  logic        rd_capture17;
  logic        acc_done17;
  logic        busy17;
`ifdef SMC_WAIT_EN
  logic        n_wait17;

  modport master (output cfg_word17, req_valid17, req_write17, n_wait17,
                  input  req_ready17, n_cs17, n_oe17, n_we17, rd_capture17, acc_done17, busy17);
  modport slave  (input  cfg_word17, req_valid17, req_write17, n_wait17,
                  output req_ready17, n_cs17, n_oe17, n_we17, rd_capture17, acc_done17, busy17);
`else
  modport master (output cfg_word17, req_valid17, req_write17,
                  input  req_ready17, n_cs17, n_oe17, n_we17, rd_capture17, acc_done17, busy17);
  modport slave  (input  cfg_word17, req_valid17, req_write17,
                  output req_ready17, n_cs17, n_oe17, n_we17, rd_capture17, acc_done17, busy17);
`endif
endinterface

// File: rtl/smc_access_seq17.sv
// Static-memory access sequencer: setup/strobe/hold/turnaround timing for one chip select.
// Define SMC_WAIT_EN to let n_wait17 stretch the last strobe cycle.
module smc_access_seq17
  import smc_seq_pkg17::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              hclk17,
  input  logic              n_sys_reset17,
  smc_access_seq17_if.slave bus
);

  if (CNT_W < 8) begin : g_bad_cnt_w
    $error("CNT_W must be at least 8 to hold the strobe length");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  cfg_t               cfg_q, cfg_d, cfg_in;
  logic               wr_q, wr_d;
  logic               accept, stall, end_enter;
  logic               n_cs_q, n_oe_q, n_we_q, rd_cap_q, done_q, busy_q;

  assign cfg_in          = cfg_unpack(bus.cfg_word17);
  assign bus.req_ready17 = (state_q == IDLE);
  assign accept          = (state_q == IDLE) && bus.req_valid17;
  assign cfg_d           = accept ? cfg_in : cfg_q;
  assign wr_d            = accept ? bus.req_write17 : wr_q;

`ifdef SMC_WAIT_EN
  assign stall = ~bus.n_wait17;
`else
  assign stall = 1'b0;
`endif

  // The END cycle is the first cycle of TURN: TURN is loaded with turn (not turn-1)
  // so the done cycle and the turnaround share one state and one count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    end_enter = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cfg_in.setup != 2'd0) begin
            state_d = SETUP;
            cnt_d   = CNT_W'(cfg_in.setup - 2'd1);
          end else begin
            state_d = STROBE;
            cnt_d   = CNT_W'(cfg_in.strobe);
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(cfg_q.strobe);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!stall) begin
          if (cfg_q.hold != 2'd0) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(cfg_q.hold - 2'd1);
          end else begin
            state_d   = TURN;
            cnt_d     = CNT_W'(cfg_q.turn);
            end_enter = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d   = TURN;
          cnt_d     = CNT_W'(cfg_q.turn);
          end_enter = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge hclk17) begin
    if (!n_sys_reset17) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cfg_q    <= '0;
      wr_q     <= 1'b0;
      n_cs_q   <= 1'b1;
      n_oe_q   <= 1'b1;
      n_we_q   <= 1'b1;
      rd_cap_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      wr_q     <= wr_d;
      n_cs_q   <= !(state_d == SETUP || state_d == STROBE || state_d == HOLD);
      n_oe_q   <= !(state_d == STROBE && !wr_d);
      n_we_q   <= !(state_d == STROBE && wr_d);
      rd_cap_q <= (state_d == STROBE) && (cnt_d == '0) && !wr_d;
      done_q   <= end_enter;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.n_cs17     = n_cs_q;
  assign bus.n_oe17     = n_oe_q;
  assign bus.n_we17     = n_we_q;
  assign bus.acc_done17 = done_q;
  assign bus.busy17     = busy_q;
`ifdef SMC_WAIT_EN
  // Wait is only known in the cycle itself, so qualify the last-strobe flag with it.
  assign bus.rd_capture17 = rd_cap_q & bus.n_wait17;
`else
  assign bus.rd_capture17 = rd_cap_q;
`endif

endmodule

// File: tb/tb_smc_access_seq17.sv
// Directed bench for smc_access_seq17: per-cycle compare against a timeline model plus literal checks.
module tb_smc_access_seq17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic wait_n = 1'b1;

  smc_access_seq17_if sif();
  smc_access_seq17 #(.CNT_W(8)) dut (.hclk17(clk), .n_sys_reset17(rst_n), .bus(sif));
`ifdef SMC_WAIT_EN
  assign sif.n_wait17 = wait_n;
`endif

  typedef struct packed {
    logic cs, oe, we, rc, done, last;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0, errors = 0;
  bit   started = 0;
  int   acc_cnt = 0;

  // Expanded per-cycle output timeline of one access, built from the phase lengths alone.
  function automatic void push_access(input logic [31:0] w, input logic wr);
    int s, h, t, st;
    s  = int'(w[1:0]);
    h  = int'(w[3:2]);
    t  = int'(w[5:4]);
    st = int'(w[15:8]);
    for (int i = 0; i < s; i++) q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i <= st; i++)
      q.push_back('{1'b0, wr, !wr, (i == st) && !wr, 1'b0, i == st});
    for (int i = 0; i < h; i++) q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < t; i++) q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
  endfunction

  always begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      started = 1;
    end else if (q.size() != 0) begin
      if (!(q[0].last && !wait_n)) void'(q.pop_front());
    end else if (sif.req_valid17) begin
      push_access(sif.cfg_word17, sif.req_write17);
      acc_cnt++;
    end
  end

  int cyc = 0;
  int cs_lo = 0, oe_lo = 0, we_lo = 0, rc_n = 0, done_n = 0;
  int last_cs = 0, last_oe = 0, last_we = 0, rc_cyc = 0;
  int last_done = 0, prev_done = 0, last_fall = 0, prev_fall = 0, rdy_rise = 0;
  logic prev_cs = 1'b1, prev_rdy = 1'b1;

  always begin
    logic [6:0] got, exp;
    @(negedge clk);
    cyc++;
    if (started) begin
      got = {sif.req_ready17, sif.busy17, sif.n_cs17, sif.n_oe17, sif.n_we17,
             sif.rd_capture17, sif.acc_done17};
      if (q.size() == 0) exp = 7'b1011100;
      else exp = {1'b0, 1'b1, q[0].cs, q[0].oe, q[0].we, q[0].rc & wait_n, q[0].done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_outputs cyc=%0d got=%b want=%b (ready,busy,cs,oe,we,rc,done)",
                 cyc, got, exp);
      end
      if (!sif.n_cs17) begin cs_lo++; last_cs = cyc; end
      if (!sif.n_cs17 && prev_cs) begin prev_fall = last_fall; last_fall = cyc; end
      if (!sif.n_oe17) begin oe_lo++; last_oe = cyc; end
      if (!sif.n_we17) begin we_lo++; last_we = cyc; end
      if (sif.rd_capture17) begin rc_n++; rc_cyc = cyc; end
      if (sif.acc_done17) begin done_n++; prev_done = last_done; last_done = cyc; end
      if (sif.req_ready17 && !prev_rdy) rdy_rise = cyc;
      prev_cs  = sif.n_cs17;
      prev_rdy = sif.req_ready17;
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  int b_cs, b_oe, b_we, b_rc, b_done;
  task automatic snap();
    b_cs = cs_lo; b_oe = oe_lo; b_we = we_lo; b_rc = rc_n; b_done = done_n;
  endtask

  function automatic logic [31:0] cfg(input int s, input int h, input int t, input int st);
    // Upper and gap bits set on purpose: they must be ignored.
    return {16'hA5A5, 8'(st), 2'b11, 2'(t), 2'(h), 2'(s)};
  endfunction

  task automatic issue(input logic [31:0] w, input logic wr);
    @(posedge clk); #2;
    sif.cfg_word17 = w; sif.req_write17 = wr; sif.req_valid17 = 1'b1;
    @(posedge clk); #2;
    sif.req_valid17 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (sif.req_ready17 && !sif.busy17) begin ok = 1; break; end
    end
    chk({name, "_idle_timeout"}, int'(ok), 1);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    sif.req_valid17 = 1'b0; sif.req_write17 = 1'b0; sif.cfg_word17 = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_ready", int'(sif.req_ready17), 1);
    chk("rst_ncs", int'(sif.n_cs17), 1);
    chk("rst_busy", int'(sif.busy17), 0);
    chk("rst_done", int'(sif.acc_done17), 0);

    // Read: setup1 strobe3 hold1 turn0
    snap();
    issue(cfg(1, 1, 0, 3), 1'b0);
    wait_idle("t1");
    chk("t1_cs_lo", cs_lo - b_cs, 6);
    chk("t1_oe_lo", oe_lo - b_oe, 4);
    chk("t1_we_lo", we_lo - b_we, 0);
    chk("t1_rc_n", rc_n - b_rc, 1);
    chk("t1_rc_at_last_strobe", rc_cyc, last_oe);
    chk("t1_done_after_hold", last_done - last_cs, 1);
    chk("t1_ready_after_done", rdy_rise - last_done, 1);

    // Minimum write
    snap();
    issue(cfg(0, 0, 0, 0), 1'b1);
    wait_idle("t2");
    chk("t2_we_lo", we_lo - b_we, 1);
    chk("t2_oe_lo", oe_lo - b_oe, 0);
    chk("t2_rc_n", rc_n - b_rc, 0);
    chk("t2_done_n", done_n - b_done, 1);
    chk("t2_done_next", last_done - last_we, 1);

    // Back-to-back reads, turn=2, valid held
    snap();
    @(posedge clk); #2;
    sif.cfg_word17 = cfg(0, 0, 2, 1); sif.req_write17 = 1'b0; sif.req_valid17 = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (acc_cnt - 2 >= 0 && ok == 0 && done_n - b_done >= 1 && sif.req_ready17 == 1'b0
          && last_fall > last_done) begin ok = 1; break; end
    end
    sif.req_valid17 = 1'b0;
    chk("t3_second_accept_timeout", int'(ok), 1);
    wait_idle("t3");
    chk("t3_done_n", done_n - b_done, 2);
    chk("t3_oe_lo", oe_lo - b_oe, 4);
    chk("t3_fall_after_done", last_fall - prev_done, 4);

    // Config change mid-strobe must not affect in-flight access
    snap();
    issue(cfg(0, 0, 0, 3), 1'b0);
    @(posedge clk); #2;
    sif.cfg_word17 = cfg(0, 0, 0, 10);
    wait_idle("t4a");
    chk("t4_inflight_oe_lo", oe_lo - b_oe, 4);
    snap();
    issue(cfg(0, 0, 0, 10), 1'b0);
    wait_idle("t4b");
    chk("t4_next_oe_lo", oe_lo - b_oe, 11);

    // Longest phases: setup3 strobe255 hold3 turn3, write
    snap();
    issue(cfg(3, 3, 3, 255), 1'b1);
    wait_idle("t5");
    chk("t5_we_lo", we_lo - b_we, 256);
    chk("t5_cs_lo", cs_lo - b_cs, 262);
    chk("t5_done_n", done_n - b_done, 1);

    // Reset during write strobe
    snap();
    issue(cfg(0, 0, 0, 5), 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t6_nwe_after_rst", int'(sif.n_we17), 1);
    chk("t6_ncs_after_rst", int'(sif.n_cs17), 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_no_done", done_n - b_done, 0);
    chk("t6_ready", int'(sif.req_ready17), 1);

`ifdef SMC_WAIT_EN
    // Wait stretches last strobe cycle of a strobe=1 read
    snap();
    issue(cfg(0, 0, 0, 1), 1'b0);
    wait_n = 1'b0;
    repeat (4) begin @(posedge clk); #2; end
    wait_n = 1'b1;
    wait_idle("t7");
    chk("t7_oe_lo", oe_lo - b_oe, 5);
    chk("t7_rc_n", rc_n - b_rc, 1);
    chk("t7_rc_at_exit", rc_cyc, last_oe);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
